// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller for one single-port synchronous SRAM (read latency 1), with first-fail capture.
// Latency: start is registered, then 10*DEPTH access cycles plus one drain cycle; done rises 10*DEPTH+2 edges after start is sampled.
// No backpressure: one SRAM access per cycle while running, start ignored while busy. Optional macro MBIST_DIAG_EN = continue on fail + fail_cnt.
module mbist_march_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mbist_start,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mbist_busy,
    output logic              mbist_done,
    output logic              mbist_fail,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
`ifdef MBIST_DIAG_EN
    ,
    output logic [CNT_W-1:0]  fail_cnt
`endif
);

    // Illegal parameterisation stops elaboration rather than building a broken sequencer.
    if (DEPTH < 2 || DEPTH > (1 << ADDR_W) || CNT_W < 1) begin : g_bad_params
        $error("mbist_march_ctrl: DEPTH must be in 2..2**ADDR_W and CNT_W >= 1");
    end

`ifdef MBIST_DIAG_EN
    localparam bit STOP_ON_FAIL = 1'b0;
`else
    localparam bit STOP_ON_FAIL = 1'b1;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        ELEM_LAST = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_start_q;
    logic               w_go;

    // March sequencer: element 0..5, address, and read/write phase of r/w elements
    logic [2:0]         r_elem;
    logic [2:0]         w_elem_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               r_wr_ph;
    logic               w_wr_ph_nxt;
    logic               w_desc;
    logic               w_rw;
    logic               w_is_read;
    logic               w_at_end;
    logic               w_step;
    logic               w_last_acc;
    logic [DATA_W-1:0]  w_wdata;
    logic [DATA_W-1:0]  w_rexp;

    // One-stage compare pipeline: describes the read issued in the previous cycle
    logic               r_cmp_vld;
    logic [DATA_W-1:0]  r_cmp_exp;
    logic [ADDR_W-1:0]  r_cmp_addr;
    logic [2:0]         r_cmp_elem;
    logic               w_cmp_act;
    logic               w_mismatch;

    logic               r_fail;
    logic [2:0]         r_fail_elem;
    logic [ADDR_W-1:0]  r_fail_addr;
    logic [DATA_W-1:0]  r_fail_data;

    logic               w_cs;
    logic               w_busy;
    logic               w_done;

    assign w_go = r_start_q && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Register the start pulse; only honoured while idle or done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= mbist_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        end
    end

    // Decode the current March step and compute the following one
    always_comb begin
        w_desc     = (r_elem == 3'd3) || (r_elem == 3'd4);
        w_rw       = (r_elem != 3'd0) && (r_elem != ELEM_LAST);
        w_is_read  = (r_elem == ELEM_LAST) || (w_rw && !r_wr_ph);
        w_at_end   = w_desc ? (r_addr == '0) : (r_addr == LAST_ADDR);
        w_step     = !w_rw || r_wr_ph;
        w_last_acc = (r_elem == ELEM_LAST) && w_at_end;
        w_wdata    = ((r_elem == 3'd1) || (r_elem == 3'd3)) ? '1 : '0;
        w_rexp     = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? '1 : '0;

        w_elem_nxt  = r_elem;
        w_addr_nxt  = r_addr;
        w_wr_ph_nxt = r_wr_ph;
        if (!w_step) begin
            w_wr_ph_nxt = 1'b1;
        end else begin
            w_wr_ph_nxt = 1'b0;
            if (w_at_end) begin
                // wrap straight into the next element's start address
                w_elem_nxt = r_elem + 3'd1;
                w_addr_nxt = ((w_elem_nxt == 3'd3) || (w_elem_nxt == 3'd4)) ? LAST_ADDR : '0;
            end else begin
                w_addr_nxt = w_desc ? (r_addr - 1'b1) : (r_addr + 1'b1);
            end
        end
    end

    // Advance the sequencer once per access; restart from M0 address 0 on start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_elem  <= 3'd0;
            r_addr  <= '0;
            r_wr_ph <= 1'b0;
        end else if (w_go) begin
            r_elem  <= 3'd0;
            r_addr  <= '0;
            r_wr_ph <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_elem  <= w_elem_nxt;
            r_addr  <= w_addr_nxt;
            r_wr_ph <= w_wr_ph_nxt;
        end
    end

    // Hold expected value/address/element of each read for next-cycle compare
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmp_vld  <= 1'b0;
            r_cmp_exp  <= '0;
            r_cmp_addr <= '0;
            r_cmp_elem <= 3'd0;
        end else begin
            r_cmp_vld <= (r_state == ST_RUN) && w_is_read;
            if ((r_state == ST_RUN) && w_is_read) begin
                r_cmp_exp  <= w_rexp;
                r_cmp_addr <= r_addr;
                r_cmp_elem <= r_elem;
            end
        end
    end

    // A read issued just before an early stop is never compared once in DONE
    assign w_cmp_act  = r_cmp_vld && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_mismatch = w_cmp_act && (mem_rdata != r_cmp_exp);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state control outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cs        = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_cs   = 1'b1;
                w_busy = 1'b1;
                // a mismatch seen in the final access cycle keeps normal timing
                if (w_last_acc) begin
                    w_state_nxt = ST_DRAIN;
                end else if (STOP_ON_FAIL && w_mismatch) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DRAIN: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (w_go) w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sticky fail flag and first-failure diagnostics, cleared by start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fail      <= 1'b0;
            r_fail_elem <= 3'd0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (w_go) begin
            r_fail      <= 1'b0;
            r_fail_elem <= 3'd0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (w_mismatch && !r_fail) begin
            r_fail      <= 1'b1;
            r_fail_elem <= r_cmp_elem;
            r_fail_addr <= r_cmp_addr;
            r_fail_data <= mem_rdata ^ r_cmp_exp;
        end
    end

`ifdef MBIST_DIAG_EN
    logic [CNT_W-1:0] r_fail_cnt;

    // Saturating count of every mismatching read in the run
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fail_cnt <= '0;
        end else if (w_go) begin
            r_fail_cnt <= '0;
        end else if (w_mismatch && (r_fail_cnt != '1)) begin
            r_fail_cnt <= r_fail_cnt + 1'b1;
        end
    end

    assign fail_cnt = r_fail_cnt;
`else
    // stop-on-first-fail build: no failure counter
`endif

    // SRAM port is decoded from registered state, so reset clears it at once
    assign mem_cs     = w_cs;
    assign mem_we     = w_cs && !w_is_read;
    assign mem_addr   = w_cs ? r_addr : '0;
    assign mem_wdata  = (w_cs && !w_is_read) ? w_wdata : '0;
    assign mbist_busy = w_busy;
    assign mbist_done = w_done;
    assign mbist_fail = r_fail;
    assign fail_elem  = r_fail_elem;
    assign fail_addr  = r_fail_addr;
    assign fail_data  = r_fail_data;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty SRAM model, March C- reference model, access/result scoreboard.
// Each start pushes the full expected access stream and final result; a negedge monitor pops and compares.
// Works with or without MBIST_DIAG_EN.
module tb_mbist_march_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int D     = 16;
    localparam int CW    = 8;
    localparam int TOTAL = 10 * D;

    // March C- read/write values per element; -1 means no such operation
    localparam int RD_VAL [6] = '{-1, 0, 1, 0, 1, 0};
    localparam int WR_VAL [6] = '{ 0, 1, 0, 1, 0, -1};

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          mbist_start = 1'b0;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mbist_busy, mbist_done, mbist_fail;
    logic [2:0]    fail_elem;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
`ifdef MBIST_DIAG_EN
    logic [CW-1:0] fail_cnt;
`endif

    mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D), .CNT_W(CW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mbist_start (mbist_start),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mbist_busy  (mbist_busy),
        .mbist_done  (mbist_done),
        .mbist_fail  (mbist_fail),
        .fail_elem   (fail_elem),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data)
`ifdef MBIST_DIAG_EN
        ,
        .fail_cnt    (fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- SRAM with a single injectable stuck-at fault on the read path
    logic [DW-1:0] sram [2**AW];
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_sa0  = '0;
    logic [DW-1:0] f_sa1  = '0;

    function automatic logic [DW-1:0] sram_read(input logic [DW-1:0] v, input int a);
        if (a == int'(f_addr)) return (v & ~f_sa0) | f_sa1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram_read(sram[mem_addr], int'(mem_addr));
        end
    end

    // ---------------- scoreboard
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    typedef struct {
        int            done_cyc;
        int            busy;
        bit            fail;
        int            elem;
        int            addr;
        logic [DW-1:0] data;
        int            cnt;
    } res_t;

    acc_t q_acc [$];
    res_t q_res [$];

    // Walk the March C- algorithm over an ideal memory seen through the fault,
    // then trim the access list according to the stop-on-fail rule.
    task automatic predict(input int e0);
        logic [DW-1:0] mm [D];
        acc_t acc [$];
        res_t r;
        int first_k, nmis, c, n_iss, done_off;
        first_k = -1; nmis = 0;
        r.fail = 0; r.elem = 0; r.addr = 0; r.data = '0; r.cnt = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < D; i++) begin
                int a;
                logic [DW-1:0] ev, got;
                a = (e == 3 || e == 4) ? (D - 1 - i) : i;
                if (RD_VAL[e] >= 0) begin
                    ev  = (RD_VAL[e] == 1) ? {DW{1'b1}} : {DW{1'b0}};
                    got = sram_read(mm[a], a);
                    acc.push_back({1'b0, AW'(a), {DW{1'b0}}});
                    if (got !== ev) begin
                        nmis++;
                        if (first_k < 0) begin
                            first_k = acc.size() - 1;
                            r.fail = 1; r.elem = e; r.addr = a; r.data = got ^ ev;
                        end
                    end
                end
                if (WR_VAL[e] >= 0) begin
                    mm[a] = (WR_VAL[e] == 1) ? {DW{1'b1}} : {DW{1'b0}};
                    acc.push_back({1'b1, AW'(a), mm[a]});
                end
            end
        end
        c = first_k + 1;   // cycle (from first access) in which the first bad read is compared
`ifdef MBIST_DIAG_EN
        n_iss    = TOTAL;
        done_off = TOTAL + 1;
        r.cnt    = (nmis > 2**CW - 1) ? 2**CW - 1 : nmis;
`else
        if (first_k >= 0 && c <= TOTAL - 2) begin
            n_iss    = c + 1;
            done_off = c + 1;
        end else begin
            n_iss    = TOTAL;
            done_off = TOTAL + 1;
        end
`endif
        r.done_cyc = e0 + 1 + done_off;
        r.busy     = done_off;
        for (int k = 0; k < n_iss; k++) q_acc.push_back(acc[k]);
        q_res.push_back(r);
    endtask

    // ---------------- monitor
    bit prev_done = 0;
    bit prev_busy = 0;
    int busy_cnt  = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (mem_cs) begin
                if (q_acc.size() == 0) begin
                    chk("spurious_access", {mem_we, mem_addr}, 0);
                end else begin
                    acc_t ex;
                    ex = q_acc.pop_front();
                    chk("access", {mem_we, mem_addr, mem_we ? mem_wdata : {DW{1'b0}}}, ex);
                end
            end
            if (mbist_busy && !prev_busy) busy_cnt = 0;
            if (mbist_busy) busy_cnt++;
            if (mbist_done && !prev_done) begin
                if (q_res.size() == 0) begin
                    chk("unexpected_done", mbist_done, 0);
                end else begin
                    res_t r;
                    r = q_res.pop_front();
                    chk("done_cycle", cyc, r.done_cyc);
                    chk("busy_cycles", busy_cnt, r.busy);
                    chk("fail", mbist_fail, r.fail);
                    chk("fail_elem", fail_elem, r.elem);
                    chk("fail_addr", fail_addr, r.addr);
                    chk("fail_data", fail_data, r.data);
`ifdef MBIST_DIAG_EN
                    chk("fail_cnt", fail_cnt, r.cnt);
`endif
                    chk("accesses_left", q_acc.size(), 0);
                end
            end
        end
        prev_done = mbist_done;
        prev_busy = mbist_busy;
    end

    // ---------------- stimulus
    task automatic check_all_zero(input string tag);
        chk({tag, "_cs"}, mem_cs, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, mbist_busy, 0);
        chk({tag, "_done"}, mbist_done, 0);
        chk({tag, "_fail"}, mbist_fail, 0);
        chk({tag, "_fdiag"}, {fail_elem, fail_addr, fail_data}, 0);
`ifdef MBIST_DIAG_EN
        chk({tag, "_cnt"}, fail_cnt, 0);
`endif
    endtask

    task automatic start_pulse();
        int e0;
        @(negedge clk);
        e0 = cyc + 1;
        predict(e0);
        mbist_start = 1'b1;
        @(negedge clk);
        mbist_start = 1'b0;
        @(negedge clk);
        // one edge after the sampling edge: flags cleared, test running
        chk("start_done_clr", mbist_done, 0);
        chk("start_fail_clr", mbist_fail, 0);
        chk("start_busy", mbist_busy, 1);
    endtask

    task automatic run_test(input int glitch);
        start_pulse();
        for (int t = 2; t < TOTAL + 20 && q_res.size() != 0; t++) begin
            mbist_start = (glitch > 0 && t == glitch);
            @(negedge clk);
        end
        mbist_start = 1'b0;
        if (q_res.size() != 0) begin
            chk("done_timeout", q_res.size(), 0);
            q_res.delete();
            q_acc.delete();
        end
    endtask

    task automatic set_fault(input int typ, input int a, input int b);
        f_addr = AW'(a);
        f_sa0  = '0;
        f_sa1  = '0;
        if (typ == 1) f_sa0[b] = 1'b1;
        if (typ == 2) f_sa1[b] = 1'b1;
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // clean memory, then clean with a start pulse while busy
        set_fault(0, 0, 0);
        run_test(0);
        run_test(40);

        // stuck-at-0 bit 3 at address 5
        set_fault(1, 5, 3);
        run_test(0);
        chk("sa0_elem", fail_elem, 2);
        chk("sa0_addr", fail_addr, 5);
        chk("sa0_data", fail_data, 8'h08);
`ifdef MBIST_DIAG_EN
        chk("sa0_cnt", fail_cnt, 2);
`endif

        // stuck-at-1 bit 0 at address 0, started from DONE after a failure
        set_fault(2, 0, 0);
        run_test(0);
        chk("sa1_elem", fail_elem, 1);
        chk("sa1_addr", fail_addr, 0);
        chk("sa1_data", fail_data, 8'h01);
`ifdef MBIST_DIAG_EN
        chk("sa1_cnt", fail_cnt, 3);
`endif

        // restart from a failed DONE on clean memory
        set_fault(0, 0, 0);
        run_test(0);

        // reset 50 cycles into a run, then a clean rerun
        start_pulse();
        repeat (50) @(negedge clk);
        #1 rstn = 1'b0;
        #1 check_all_zero("midreset");
        q_acc.delete();
        q_res.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        run_test(0);
        chk("post_reset_fail", mbist_fail, 0);

        // randomised faults
        for (int n = 0; n < 12; n++) begin
            int typ, g;
            typ = $urandom_range(0, 2);
            set_fault(typ, $urandom_range(0, D - 1), $urandom_range(0, DW - 1));
            g = (typ == 0) ? $urandom_range(5, 150) : 0;
            run_test(g);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- Parametrised memory BIST controller. Runs the March C- algorithm on one external single-port synchronous SRAM, compares read data and reports pass/fail with failure diagnostics.
- Next-generation BIST engine: address width, data width and depth are parameters; it adds first-fail capture and an optional diagnostic (continue-on-fail) mode.
- Sits between the top-level test controller (start/done) and the SRAM macro port.

Parameters:
ADDR_W, 4, SRAM address width
DATA_W, 8, SRAM word width
DEPTH, 16, number of words tested (2 <= DEPTH <= 2**ADDR_W); addresses 0..DEPTH-1
CNT_W, 8, failure-counter width (used only with MBIST_DIAG_EN)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
mbist_start  in  1  start pulse, sampled only in IDLE or DONE
mem_cs  out  1  SRAM chip select, active high
mem_we  out  1  SRAM write enable (1=write, 0=read) when mem_cs=1
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read access (latency 1)
mbist_busy  out  1  high while the test runs (RUN and DRAIN)
mbist_done  out  1  sticky test-complete flag
mbist_fail  out  1  sticky fail flag, valid when mbist_done=1
fail_elem  out  3  March element of the first failure (0..5)
fail_addr  out  ADDR_W  address of the first failure
fail_data  out  DATA_W  mem_rdata XOR expected at the first failure (bit map)
fail_cnt  out  CNT_W  total mismatching reads, saturating (present only with MBIST_DIAG_EN)

Behaviour:
- Reset (async): FSM=IDLE. All outputs 0: mem_cs, mem_we, mem_addr, mem_wdata, busy, done, fail, fail_elem, fail_addr, fail_data, fail_cnt. Reset mid-test aborts immediately; mem_cs drops asynchronously.
- States: IDLE -> RUN -> DRAIN -> DONE. mbist_start=1 in IDLE or DONE moves to RUN and clears done/fail/fail_* /fail_cnt. mbist_start is ignored while busy.
- March C- elements (B0 = all-0 word, B1 = all-1 word):
  - M0 ⇕ w0, ascending.
  - M1 ⇑ (r0, w1).
  - M2 ⇑ (r1, w0).
  - M3 ⇓ (r0, w1).
  - M4 ⇓ (r1, w0).
  - M5 ⇕ r0, ascending.
- One SRAM access per cycle, mem_cs=1 throughout RUN.
  - Read-write elements: read at addr in cycle t, write the same addr in cycle t+1.
  - ⇑ runs 0..DEPTH-1; ⇓ runs DEPTH-1..0. Address wraps to the next element's start with no idle cycle.
- Compare: each read is compared in the following cycle. Expected value, address and element are held in a one-stage pipeline register. The mismatch test is (mem_rdata != expected).
- Accesses occupy exactly 10*DEPTH cycles. DRAIN is one cycle with mem_cs=0 and carries the final M5 compare. DONE is entered on the next edge.
- Clean memory: mbist_done rises 10*DEPTH+2 rising edges after the edge that samples mbist_start.
- DONE: mem_cs=0, busy=0. done and fail hold until reset or the next start.
- First mismatch: captures fail_elem, fail_addr and fail_data, and sets fail (only the first failure is recorded).
- Default (no macro), stop on fail:
  - The access issued in the compare cycle completes.
  - The FSM then goes straight to DONE at the next edge: mem_cs=0, done=1, fail=1.
- Simultaneous mismatch and last-access cycle: the failure is captured; timing is unchanged.
- DEPTH < 2**ADDR_W: addresses >= DEPTH are never driven.

Optional Feature:
MBIST_DIAG_EN
- Defined: the controller never stops early. The full March runs (done timing as for clean memory). fail_* capture the first failure only. Port fail_cnt counts every mismatching read, saturating at 2**CNT_W-1 and cleared on start.
- Undefined: stop-on-first-fail as above; the fail_cnt port and counter do not exist.

Test Plan:
- Clean memory, defaults, pulse start → done=1 at edge 162 after sampling, fail=0, busy high for 161 cycles. Check the address sequence: M3/M4 descend 15..0.
- Stuck-at-0 on bit 3 of addr 5 (no macro) → fail=1, fail_elem=2, fail_addr=5, fail_data=8'h08. Done asserts one edge after the M2 compare; no accesses after it.
- Stuck-at-1 on bit 0 of addr 0 (no macro) → fail_elem=1, fail_addr=0, fail_data=8'h01.
- With MBIST_DIAG_EN:
  - Stuck-at-0 bit 3 of addr 5 → fail_cnt=2 (M2, M4), fail_elem=2, done at edge 162.
  - Stuck-at-1 bit 0 of addr 0 → fail_cnt=3 (M1, M3, M5).
- rstn low at cycle 50 of a run → all outputs 0 immediately. A new start after release runs the full test with a clean result.
- Second start pulse while busy → ignored, done timing unchanged. Start in DONE after a failure → flags clear next edge and the test reruns.
